// File: rtl/ga_pkg.sv
// ============================================================================
// Module      : ga_pkg
// Description : Shared GA types and defaults (fitness calculator, elite tracker)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ga_pkg;

    localparam int C_POP_SIZE = 16;
    localparam int C_FIT_W    = 5;

    typedef logic [C_FIT_W-1:0] fitness_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/elite_tracker.sv
// ============================================================================
// Module      : elite_tracker
// Description : Tracks the two lowest-fitness individuals of each generation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elite_tracker
    import ga_pkg::*;
#(
    parameter  int POP_SIZE = C_POP_SIZE,
    parameter  int FIT_W    = C_FIT_W,
    localparam int IDX_W    = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_start,
    input  logic             fit_valid,
    input  logic [FIT_W-1:0] fitness,
    output logic             busy,
    output logic [IDX_W-1:0] ind_idx,
    output logic [IDX_W-1:0] best_idx,
    output logic [FIT_W-1:0] best_fit,
    output logic [IDX_W-1:0] second_idx,
    output logic [FIT_W-1:0] second_fit,
    output logic             gen_done,
    output logic             solved,
    output logic [15:0]      generation
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(POP_SIZE - 1);
    localparam logic [FIT_W-1:0] c_fit_max  = '1;

    state_t           r_state;
    logic [IDX_W-1:0] r_ind_idx;
    logic [IDX_W-1:0] r_best_idx;
    logic [FIT_W-1:0] r_best_fit;
    logic [IDX_W-1:0] r_second_idx;
    logic [FIT_W-1:0] r_second_fit;
    logic             r_gen_done;
    logic             r_solved;
    logic [15:0]      r_generation;

    logic w_beats_best;
    logic w_beats_second;
    logic w_last;

    // Strict compares: an equal later fitness never displaces an earlier index
    assign w_beats_best   = (fitness < r_best_fit);
    assign w_beats_second = (fitness < r_second_fit);
    assign w_last         = (r_ind_idx == c_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ind_idx    <= '0;
            r_best_idx   <= '0;
            r_best_fit   <= c_fit_max;
            r_second_idx <= '0;
            r_second_fit <= c_fit_max;
            r_gen_done   <= 1'b0;
            r_solved     <= 1'b0;
            r_generation <= '0;
        end else begin
            r_gen_done <= 1'b0;
            if (gen_start) begin
                // A new generation wins over any coincident fitness sample
                r_state      <= ST_COLLECT;
                r_ind_idx    <= '0;
                r_best_idx   <= '0;
                r_best_fit   <= c_fit_max;
                r_second_idx <= '0;
                r_second_fit <= c_fit_max;
                r_solved     <= 1'b0;
            end else begin
                case (r_state)
                    ST_COLLECT: begin
                        if (fit_valid) begin
                            if (w_beats_best) begin
                                r_second_idx <= r_best_idx;
                                r_second_fit <= r_best_fit;
                                r_best_idx   <= r_ind_idx;
                                r_best_fit   <= fitness;
                            end else if (w_beats_second) begin
                                r_second_idx <= r_ind_idx;
                                r_second_fit <= fitness;
                            end
                            if (fitness == '0) begin
                                r_solved <= 1'b1;
                            end
                            if (w_last) begin
                                r_state      <= ST_DONE;
                                r_gen_done   <= 1'b1;
                                r_generation <= r_generation + 16'd1;
                            end else begin
                                r_ind_idx <= r_ind_idx + 1'b1;
                            end
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy       = (r_state == ST_COLLECT);
    assign ind_idx    = r_ind_idx;
    assign best_idx   = r_best_idx;
    assign best_fit   = r_best_fit;
    assign second_idx = r_second_idx;
    assign second_fit = r_second_fit;
    assign gen_done   = r_gen_done;
    assign solved     = r_solved;
    assign generation = r_generation;

endmodule

`default_nettype wire

// File: tb/tb_elite_tracker.sv
// ============================================================================
// Module      : tb_elite_tracker
// Description : Scoreboard bench for elite_tracker with POP_SIZE=4
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elite_tracker;
    import ga_pkg::*;

    localparam int       c_pop     = 4;
    localparam fitness_t c_fit_max = '1;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_start;
    logic        fit_valid;
    fitness_t    fitness;
    logic        busy;
    logic [1:0]  ind_idx;
    logic [1:0]  best_idx;
    fitness_t    best_fit;
    logic [1:0]  second_idx;
    fitness_t    second_fit;
    logic        gen_done;
    logic        solved;
    logic [15:0] generation;

    typedef struct {
        logic [1:0]  bi;
        fitness_t    bf;
        logic [1:0]  si;
        fitness_t    sf;
        logic        solved;
        logic [15:0] gen;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        last_exp;
    logic [15:0] gen_model = '0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    elite_tracker #(.POP_SIZE(c_pop), .FIT_W(C_FIT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .gen_start  (gen_start),
        .fit_valid  (fit_valid),
        .fitness    (fitness),
        .busy       (busy),
        .ind_idx    (ind_idx),
        .best_idx   (best_idx),
        .best_fit   (best_fit),
        .second_idx (second_idx),
        .second_fit (second_fit),
        .gen_done   (gen_done),
        .solved     (solved),
        .generation (generation)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: first minimum, then first minimum among the remaining indices
    function automatic exp_t model(input fitness_t f[4]);
        exp_t e;
        e.bi = '0; e.bf = c_fit_max; e.si = '0; e.sf = c_fit_max; e.solved = 1'b0; e.gen = '0;
        for (int i = 0; i < c_pop; i++) begin
            if (f[i] < e.bf) begin e.bf = f[i]; e.bi = 2'(i); end
            if (f[i] == '0) e.solved = 1'b1;
        end
        for (int i = 0; i < c_pop; i++) begin
            if (2'(i) != e.bi && f[i] < e.sf) begin e.sf = f[i]; e.si = 2'(i); end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (gen_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_gen_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("best_idx",   best_idx,   mon_e.bi);
                check("best_fit",   best_fit,   mon_e.bf);
                check("second_idx", second_idx, mon_e.si);
                check("second_fit", second_fit, mon_e.sf);
                check("solved",     solved,     mon_e.solved);
                check("generation", generation, mon_e.gen);
                last_exp = mon_e;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        gen_start = 1'b1;
        @(negedge clk);
        gen_start = 1'b0;
        check("start_busy",      busy,       32'd1);
        check("start_ind_idx",   ind_idx,    32'd0);
        check("start_best_fit",  best_fit,   c_fit_max);
        check("start_second_fit",second_fit, c_fit_max);
        check("start_solved",    solved,     32'd0);
    endtask

    task automatic run_gen(input fitness_t f[4], input bit fv_in_done);
        exp_t e;
        pulse_start();
        for (int i = 0; i < c_pop; i++) begin
            fit_valid = 1'b1;
            fitness   = f[i];
            if (i == c_pop - 1) begin
                gen_model = gen_model + 16'd1;
                e     = model(f);
                e.gen = gen_model;
                sb.push_back(e);
            end
            @(negedge clk);
            if (i < c_pop - 1) check("ind_idx_step", ind_idx, 32'(i + 1));
        end
        check("gen_done_pulse", gen_done, 32'd1);
        check("done_not_busy",  busy,     32'd0);
        if (fv_in_done) fitness = '0;
        else            fit_valid = 1'b0;
        @(negedge clk);
        fit_valid = 1'b0;
        check("gen_done_one_cycle", gen_done, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},       busy,       32'd0);
        check({tag, "_gen_done"},   gen_done,   32'd0);
        check({tag, "_solved"},     solved,     32'd0);
        check({tag, "_ind_idx"},    ind_idx,    32'd0);
        check({tag, "_best_idx"},   best_idx,   32'd0);
        check({tag, "_second_idx"}, second_idx, 32'd0);
        check({tag, "_generation"}, generation, 32'd0);
        check({tag, "_best_fit"},   best_fit,   c_fit_max);
        check({tag, "_second_fit"}, second_fit, c_fit_max);
    endtask

    task automatic check_elite_held(input string tag);
        check({tag, "_best_idx"},   best_idx,   last_exp.bi);
        check({tag, "_best_fit"},   best_fit,   last_exp.bf);
        check({tag, "_second_idx"}, second_idx, last_exp.si);
        check({tag, "_second_fit"}, second_fit, last_exp.sf);
        check({tag, "_solved"},     solved,     last_exp.solved);
        check({tag, "_ind_idx"},    ind_idx,    32'(c_pop - 1));
    endtask

    initial begin
        fitness_t f[4];
        rst = 1'b1; gen_start = 1'b0; fit_valid = 1'b0; fitness = '0;
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        f = '{5'd10, 5'd3, 5'd7, 5'd12};
        run_gen(f, 1'b0);
        f = '{5'd5, 5'd5, 5'd9, 5'd5};
        run_gen(f, 1'b0);
        f = '{5'd4, 5'd0, 5'd8, 5'd2};
        run_gen(f, 1'b1);
        // Sample offered during DONE and in IDLE must be ignored
        check_elite_held("done_fv");
        repeat (2) begin
            fit_valid = 1'b1; fitness = '0;
            @(negedge clk);
            fit_valid = 1'b0;
            @(negedge clk);
        end
        check_elite_held("idle_fv");
        check("idle_generation", generation, gen_model);

        // Restart collides with the third sample
        pulse_start();
        fit_valid = 1'b1; fitness = 5'd6;
        @(negedge clk);
        fitness = 5'd9;
        @(negedge clk);
        fitness = 5'd0; gen_start = 1'b1;
        @(negedge clk);
        gen_start = 1'b0; fit_valid = 1'b0;
        check("restart_ind_idx",  ind_idx,    32'd0);
        check("restart_solved",   solved,     32'd0);
        check("restart_best_fit", best_fit,   c_fit_max);
        check("restart_best_idx", best_idx,   32'd0);
        check("restart_second",   second_fit, c_fit_max);
        check("restart_busy",     busy,       32'd1);
        check("restart_gen_done", gen_done,   32'd0);
        check("restart_gen",      generation, gen_model);
        f = '{5'd8, 5'd6, 5'd6, 5'd1};
        run_gen(f, 1'b0);

        // Asynchronous reset part-way through a generation
        pulse_start();
        fit_valid = 1'b1; fitness = 5'd0;
        @(negedge clk);
        fitness = 5'd4;
        @(negedge clk);
        fit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        gen_model = '0;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        f = '{5'd3, 5'd2, 5'd1, 5'd7};
        run_gen(f, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
